// File: rtl/store_unit.sv
// rtl/store_unit.sv - sb/sh/sw store executor with read-modify-write for sub-word stores
module store_unit #(
  parameter int ADDR_WIDTH   = 32,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [2:0]            funct3,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [31:0]           wdata,
  output logic                  busy,
  output logic                  done,
  output logic                  fault,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_re,
  input  logic [31:0]           mem_rdata,
  output logic                  mem_we,
  output logic [31:0]           mem_wdata
);

  typedef enum logic [2:0] {IDLE, READ, WRITE, FAULT, DONE} state_t;

  localparam int CW = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

  state_t        state;
  logic [CW-1:0] rd_cnt;
  logic [1:0]    lane_q;
  logic          half_q;
  logic [15:0]   wdata_q;

  logic is_sb, is_sh, is_sw, bad;

  always_comb begin
    is_sb = (funct3 == 3'b000);
    is_sh = (funct3 == 3'b001);
    is_sw = (funct3 == 3'b010);
    bad   = !(is_sb || is_sh || is_sw) || (is_sh && addr[0]) || (is_sw && (addr[1:0] != 2'b00));
  end

  // Replace the addressed byte or halfword of the old word, keep the rest.
  function automatic logic [31:0] merge(input logic [31:0] old, input logic [15:0] d,
                                        input logic half, input logic [1:0] lane);
    logic [31:0] w;
    w = old;
    if (half) begin
      if (lane[1]) w[31:16] = d;
      else         w[15:0]  = d;
    end else begin
      case (lane)
        2'd0: w[7:0]   = d[7:0];
        2'd1: w[15:8]  = d[7:0];
        2'd2: w[23:16] = d[7:0];
        default: w[31:24] = d[7:0];
      endcase
    end
    return w;
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      rd_cnt    <= '0;
      lane_q    <= '0;
      half_q    <= 1'b0;
      wdata_q   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      fault     <= 1'b0;
      mem_re    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            lane_q  <= addr[1:0];
            half_q  <= funct3[0];
            wdata_q <= wdata[15:0];
            busy    <= 1'b1;
            if (bad) begin
              state <= FAULT;
            end else begin
              mem_addr <= {addr[ADDR_WIDTH-1:2], 2'b00};
              if (is_sw) begin
                mem_we    <= 1'b1;
                mem_wdata <= wdata;
                state     <= WRITE;
              end else begin
                mem_re <= 1'b1;
                rd_cnt <= '0;
                state  <= READ;
              end
            end
          end
        end
        READ: begin
          // Read data is valid at the end of the last strobe cycle.
          if (rd_cnt == CW'(READ_LATENCY - 1)) begin
            mem_re    <= 1'b0;
            mem_we    <= 1'b1;
            mem_wdata <= merge(mem_rdata, wdata_q, half_q, lane_q);
            state     <= WRITE;
          end else begin
            rd_cnt <= rd_cnt + CW'(1);
          end
        end
        WRITE: begin
          mem_we <= 1'b0;
          done   <= 1'b1;
          state  <= DONE;
        end
        FAULT: begin
          done  <= 1'b1;
          fault <= 1'b1;
          state <= DONE;
        end
        DONE: begin
          done  <= 1'b0;
          fault <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy   <= 1'b0;
          done   <= 1'b0;
          fault  <= 1'b0;
          mem_re <= 1'b0;
          mem_we <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_store_unit.sv
// tb/tb_store_unit.sv - randomized and directed checks of store_unit at read latencies 1 and 3
module tb_store_unit;

  typedef struct {
    logic        busy, re, we, done, fault;
    logic [31:0] addr, data;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  funct3 = 3'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;

  logic        busy[2], done[2], fault[2], mem_re[2], mem_we[2];
  logic [31:0] mem_addr[2], mem_wdata[2], mem_rdata[2];

  logic [31:0] bmem[2][16] = '{default: 32'h0};
  logic [31:0] ref_mem[2][16] = '{default: 32'h0};
  exp_t        sched[2][$];
  int          re_cnt[2] = '{0, 0};
  int          wr_cnt[2] = '{0, 0};
  logic [31:0] garbage = 32'h0;

  int n_chk = 0;
  int n_fail = 0;
  int lat[2], recnt[2], dcnt[2];
  logic fl[2];

  always #5 clk = ~clk;

  store_unit #(.ADDR_WIDTH(32), .READ_LATENCY(1)) u0 (
    .clk(clk), .reset(reset), .start(start), .funct3(funct3), .addr(addr), .wdata(wdata),
    .busy(busy[0]), .done(done[0]), .fault(fault[0]), .mem_addr(mem_addr[0]), .mem_re(mem_re[0]),
    .mem_rdata(mem_rdata[0]), .mem_we(mem_we[0]), .mem_wdata(mem_wdata[0]));

  store_unit #(.ADDR_WIDTH(32), .READ_LATENCY(3)) u1 (
    .clk(clk), .reset(reset), .start(start), .funct3(funct3), .addr(addr), .wdata(wdata),
    .busy(busy[1]), .done(done[1]), .fault(fault[1]), .mem_addr(mem_addr[1]), .mem_re(mem_re[1]),
    .mem_rdata(mem_rdata[1]), .mem_we(mem_we[1]), .mem_wdata(mem_wdata[1]));

  function automatic int rl(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d: got %h expected %h at %0t", name, k, act, exp, $time);
    end
  endtask

  // Memory: read data only valid on the last strobe cycle of a read, junk otherwise.
  always @(posedge clk) begin
    garbage <= $urandom;
    for (int k = 0; k < 2; k++) begin
      re_cnt[k] <= mem_re[k] ? re_cnt[k] + 1 : 0;
      if (mem_we[k]) begin
        bmem[k][mem_addr[k][5:2]] <= mem_wdata[k];
        wr_cnt[k] <= wr_cnt[k] + 1;
      end
    end
  end

  always_comb begin
    for (int k = 0; k < 2; k++)
      mem_rdata[k] = (mem_re[k] && re_cnt[k] == rl(k) - 1) ? bmem[k][mem_addr[k][5:2]] : garbage;
  end

  // Expected per-cycle output timeline of one accepted store.
  task automatic plan(input int k);
    exp_t        e;
    logic [31:0] wa, old, nw;
    int          sh;
    logic        bad;
    wa  = {addr[31:2], 2'b00};
    bad = (funct3 > 2) || (funct3 == 1 && addr % 2 != 0) || (funct3 == 2 && addr % 4 != 0);
    e = '{default: 0};
    e.busy = 1'b1;
    if (bad) begin
      sched[k].push_back(e);
      e.done = 1'b1;
      e.fault = 1'b1;
      sched[k].push_back(e);
      return;
    end
    if (funct3 == 2) begin
      nw = wdata;
    end else begin
      old = ref_mem[k][addr[5:2]];
      if (funct3 == 0) begin
        sh = 8 * int'(addr % 4);
        nw = (old & ~(32'hff << sh)) | ((wdata & 32'hff) << sh);
      end else begin
        sh = 16 * int'((addr / 2) % 2);
        nw = (old & ~(32'hffff << sh)) | ((wdata & 32'hffff) << sh);
      end
      e.re = 1'b1;
      e.addr = wa;
      repeat (rl(k)) sched[k].push_back(e);
    end
    e.re = 1'b0;
    e.we = 1'b1;
    e.addr = wa;
    e.data = nw;
    sched[k].push_back(e);
    e.we = 1'b0;
    e.done = 1'b1;
    sched[k].push_back(e);
  endtask

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < 2; k++) sched[k].delete();
    end else begin
      for (int k = 0; k < 2; k++) begin
        bit   idle;
        exp_t e;
        idle = (sched[k].size() == 0);
        if (!idle) begin
          e = sched[k].pop_front();
          if (e.we) ref_mem[k][e.addr[5:2]] = e.data;
        end
        if (idle && start) plan(k);
      end
    end
  end

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      exp_t e;
      e = '{default: 0};
      if (sched[k].size() != 0) e = sched[k][0];
      chk("busy", k, 32'(busy[k]), 32'(e.busy));
      chk("done", k, 32'(done[k]), 32'(e.done));
      chk("fault", k, 32'(fault[k]), 32'(e.fault));
      chk("mem_re", k, 32'(mem_re[k]), 32'(e.re));
      chk("mem_we", k, 32'(mem_we[k]), 32'(e.we));
      if (e.re || e.we) chk("mem_addr", k, mem_addr[k], e.addr);
      if (e.we) chk("mem_wdata", k, mem_wdata[k], e.data);
    end
  end

  // smask[c] is the start value sampled at edge c; inputs are scrambled whenever start is low.
  task automatic op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] d, input logic [15:0] smask);
    lat = '{0, 0}; recnt = '{0, 0}; dcnt = '{0, 0}; fl = '{1'b0, 1'b0};
    @(posedge clk);
    #1 start = smask[0]; funct3 = f; addr = a; wdata = d;
    @(posedge clk);
    for (int c = 1; c <= 14; c++) begin
      #1 start = smask[c];
      if (start) begin
        funct3 = f; addr = a; wdata = d;
      end else begin
        funct3 = 3'($urandom); addr = $urandom; wdata = $urandom;
      end
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        if (mem_re[k]) recnt[k]++;
        if (done[k]) begin
          dcnt[k]++;
          if (lat[k] == 0) begin
            lat[k] = c;
            fl[k] = fault[k];
          end
        end
      end
      @(posedge clk);
    end
  endtask

  initial begin
    int w0[2];
    #2;
    for (int k = 0; k < 2; k++) begin
      chk("rst_busy", k, 32'(busy[k]), 0);
      chk("rst_done", k, 32'(done[k]), 0);
      chk("rst_fault", k, 32'(fault[k]), 0);
      chk("rst_re_we", k, 32'({mem_re[k], mem_we[k]}), 0);
      chk("rst_mem_addr", k, mem_addr[k], 0);
      chk("rst_mem_wdata", k, mem_wdata[k], 0);
    end
    #10 reset = 1'b1;

    op(3'b010, 32'h28, 32'hdeadbeef, 16'h1);
    op(3'b010, 32'h28, 32'hcafebabe, 16'h1);
    for (int k = 0; k < 2; k++) begin
      chk("sw_latency", k, lat[k], 2);
      chk("sw_no_read", k, recnt[k], 0);
      chk("sw_word", k, bmem[k][10], 32'hcafebabe);
    end

    op(3'b010, 32'h28, 32'hdeadbeef, 16'h1);
    op(3'b000, 32'h29, 32'h000000ab, 16'h1);
    for (int k = 0; k < 2; k++) begin
      chk("sb_latency", k, lat[k], rl(k) + 2);
      chk("sb_read_cycles", k, recnt[k], rl(k));
      chk("sb_word", k, bmem[k][10], 32'hdeadabef);
    end

    op(3'b010, 32'h28, 32'hdeadbeef, 16'h1);
    op(3'b001, 32'h2a, 32'hffff1234, 16'h1);
    for (int k = 0; k < 2; k++) begin
      chk("sh_latency", k, lat[k], rl(k) + 2);
      chk("sh_read_cycles", k, recnt[k], rl(k));
      chk("sh_word", k, bmem[k][10], 32'h1234beef);
    end

    for (int t = 0; t < 3; t++) begin
      w0 = wr_cnt;
      case (t)
        0: op(3'b010, 32'h2a, 32'h11111111, 16'h1);
        1: op(3'b001, 32'h29, 32'h22222222, 16'h1);
        default: op(3'b011, 32'h28, 32'h33333333, 16'h1);
      endcase
      for (int k = 0; k < 2; k++) begin
        chk("fault_latency", k, lat[k], 2);
        chk("fault_flag", k, 32'(fl[k]), 1);
        chk("fault_no_read", k, recnt[k], 0);
        chk("fault_no_write", k, wr_cnt[k] - w0[k], 0);
        chk("fault_word", k, bmem[k][10], 32'h1234beef);
      end
    end

    w0 = wr_cnt;
    op(3'b010, 32'h28, 32'h11112222, 16'h7);
    for (int k = 0; k < 2; k++) begin
      chk("held_start_writes", k, wr_cnt[k] - w0[k], 1);
      chk("held_start_dones", k, dcnt[k], 1);
    end

    w0 = wr_cnt;
    op(3'b010, 32'h28, 32'h11112222, 16'h9);
    for (int k = 0; k < 2; k++) begin
      chk("b2b_writes", k, wr_cnt[k] - w0[k], 2);
      chk("b2b_dones", k, dcnt[k], 2);
    end

    w0 = wr_cnt;
    @(posedge clk);
    #1 start = 1'b1; funct3 = 3'b000; addr = 32'h29; wdata = 32'h000000cd;
    @(posedge clk);
    #1 start = 1'b0;
    #1 reset = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("midrst_busy", k, 32'(busy[k]), 0);
      chk("midrst_re", k, 32'(mem_re[k]), 0);
      chk("midrst_done", k, 32'(done[k]), 0);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    #2 reset = 1'b1;
    for (int k = 0; k < 2; k++) begin
      chk("midrst_no_write", k, wr_cnt[k] - w0[k], 0);
      chk("midrst_word", k, bmem[k][10], 32'h11112222);
    end
    op(3'b010, 32'h28, 32'h5a5a0f0f, 16'h1);
    for (int k = 0; k < 2; k++) begin
      chk("postrst_latency", k, lat[k], 2);
      chk("postrst_word", k, bmem[k][10], 32'h5a5a0f0f);
    end

    for (int i = 0; i < 600; i++) begin
      @(posedge clk);
      #1 start = ($urandom % 3 == 0);
      funct3 = ($urandom % 4 == 0) ? 3'($urandom) : 3'($urandom % 3);
      addr = $urandom % 64;
      wdata = $urandom;
    end
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++)
      for (int w = 0; w < 16; w++)
        chk("final_mem", k, bmem[k][w], ref_mem[k][w]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
